// File: rtl/seq_frame_pkg.sv
// seq_frame_pkg: shared types and defaults for the framed serial transmitter.
// Holds the FSM state enum, default sync pattern and counter sizing helper.
package seq_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam int SYNC_W_DEF = 4;
   localparam logic [SYNC_W_DEF-1:0] SYNC_DEF = 4'b1001;

   // Bits needed to hold (largest phase length - 1), never less than one.
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load, MSB-first shift-out payload register.
// Ports: clk, rst_n, load (capture d), shift (move left by one), d, msb.
module piso_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         msb
);

   logic [W-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         unique case (1'b1)
            load:    sr <= d;
            shift:   sr <= sr << 1;
            default: sr <= sr;
         endcase
      end
   end

   assign msb = sr[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: sends sync pattern + payload word MSB first, then idle gap.
// Ports: clk, rst_n, in_valid/in_data/in_ready (payload handshake), abort,
//        tx_out (serial line), tx_active (sync/data on line), frame_done.
module seq_frame_tx
   import seq_frame_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter int                SYNC_W  = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC    = SYNC_W'(SYNC_DEF),
   parameter int                GAP_LEN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              abort,
   output logic              tx_out,
   output logic              tx_active,
   output logic              frame_done
);

   localparam int CNT_W = cnt_w(SYNC_W, DATA_W, GAP_LEN);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SYNC_W-1:0] sync_sr;
   logic              hs;
   logic              pd_shift;
   logic              pd_msb;

   assign in_ready = rst_n && !abort && (state == ST_IDLE);
   assign hs       = in_valid && in_ready;

   // Payload MSB is consumed on the last sync edge and every data edge.
   assign pd_shift = (state == ST_DATA) ||
                     ((state == ST_SYNC) && (bit_cnt == '0));

   piso_shift #(
      .W (DATA_W)
   ) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (hs),
      .shift (pd_shift),
      .d     (in_data),
      .msb   (pd_msb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         sync_sr    <= '0;
         tx_out     <= 1'b0;
         tx_active  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx_out    <= 1'b0;
               tx_active <= 1'b0;
               if (hs) begin
                  state     <= ST_SYNC;
                  bit_cnt   <= SYNC_LAST;
                  sync_sr   <= SYNC << 1;
                  tx_out    <= SYNC[SYNC_W-1];
                  tx_active <= 1'b1;
               end
            end
            ST_SYNC: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  bit_cnt   <= '0;
                  tx_out    <= 1'b0;
                  tx_active <= 1'b0;
               end else if (bit_cnt == '0) begin
                  state   <= ST_DATA;
                  bit_cnt <= DATA_LAST;
                  tx_out  <= pd_msb;
               end else begin
                  bit_cnt <= bit_cnt - ONE;
                  tx_out  <= sync_sr[SYNC_W-1];
                  sync_sr <= sync_sr << 1;
               end
            end
            ST_DATA: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  bit_cnt   <= '0;
                  tx_out    <= 1'b0;
                  tx_active <= 1'b0;
               end else if (bit_cnt == '0) begin
                  state      <= ST_GAP;
                  bit_cnt    <= GAP_LAST;
                  tx_out     <= 1'b0;
                  tx_active  <= 1'b0;
                  frame_done <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - ONE;
                  tx_out  <= pd_msb;
               end
            end
            ST_GAP: begin
               tx_out    <= 1'b0;
               tx_active <= 1'b0;
               if (bit_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt - ONE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               bit_cnt   <= '0;
               tx_out    <= 1'b0;
               tx_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, payload bits per frame (>=1).
REQ-002 The block SHALL have parameter SYNC_W, default 4, sync-pattern length (>=1).
REQ-003 The block SHALL have parameter SYNC, default 4'b1001, sync pattern sent MSB first.
REQ-004 The block SHALL have parameter GAP_LEN, default 1, idle cycles after each frame (>=1).
REQ-005 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port in_valid, input, 1, payload offered.
REQ-008 The block SHALL have port in_data, input, DATA_W, payload word.
REQ-009 The block SHALL have port in_ready, output, 1, block can accept a payload.
REQ-010 The block SHALL have port abort, input, 1, synchronous frame abort.
REQ-011 The block SHALL have port tx_out, output, 1, serial line, registered.
REQ-012 The block SHALL have port tx_active, output, 1, high while a sync or data bit is on tx_out.
REQ-013 The block SHALL have port frame_done, output, 1, single-cycle pulse per completed frame.

Function
REQ-014 The FSM SHALL have states IDLE, SYNC, DATA, GAP, with one down-counter bit_cnt sized for max(SYNC_W, DATA_W, GAP_LEN).
REQ-015 in_ready SHALL be high only in IDLE with abort low; it SHALL be a combinational decode of state and abort.
REQ-016 A handshake SHALL occur on an edge where in_valid and in_ready are both high; in_data SHALL be captured into a shift register on that edge.
REQ-017 On handshake the FSM SHALL go IDLE->SYNC; tx_out SHALL show SYNC[SYNC_W-1] in cycle 1 after the handshake edge.
REQ-018 SYNC SHALL last SYNC_W cycles, emitting SYNC MSB first, then go to DATA.
REQ-019 DATA SHALL last DATA_W cycles, emitting the captured word MSB first, then go to GAP.
REQ-020 GAP SHALL last GAP_LEN cycles with tx_out=0, then go to IDLE.
REQ-021 frame_done SHALL pulse high in the first GAP cycle only.
REQ-022 tx_active SHALL be high exactly in SYNC and DATA cycles.
REQ-023 In IDLE, tx_out SHALL be 0.
REQ-024 The minimum handshake-to-handshake period SHALL be SYNC_W+DATA_W+GAP_LEN+1 cycles.
REQ-025 in_valid and in_data changes outside a handshake SHALL have no effect.
REQ-026 abort high in SYNC or DATA SHALL move the FSM to IDLE on the next edge, with tx_out=0 and no frame_done.
REQ-027 abort high in GAP or IDLE SHALL have no effect except blocking in_ready in IDLE.
REQ-028 abort and a would-be handshake in the same cycle SHALL result in no capture.
REQ-029 Payload bits SHALL NOT be bit-stuffed; a payload containing SYNC is the receiver's concern.
REQ-030 An illegal state encoding SHALL return the FSM to IDLE on the next edge.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, bit_cnt=0, shift register=0, tx_out=0, tx_active=0, and frame_done=0.
REQ-032 in_ready SHALL be 0 while rst_n is low, and 1 in the first cycle after release if abort is low.
REQ-033 Reset mid-frame SHALL discard the frame with no frame_done.

Structure
REQ-034 Package seq_frame_pkg SHALL hold the state enum and default SYNC/SYNC_W constants.
REQ-035 Sub-module piso_shift (parallel load, MSB-first shift-out, width parameter) SHALL hold the payload register.
REQ-036 The FSM and counter SHALL be in seq_frame_tx, with next-state logic defaulting to hold the current state.

Verification
REQ-037 Defaults, handshake in_data=8'hA5 -> tx_out cycles 1-12 = 1,0,0,1,1,0,1,0,0,1,0,1; cycle 13 tx_out=0 with frame_done=1; cycle 14 in_ready=1.
REQ-038 in_valid held high with 8'hFF then 8'h00 -> second handshake exactly 14 cycles after the first; each of the two frames carries its own word.
REQ-039 in_data changes during DATA -> emitted bits still match the word captured at handshake.
REQ-040 abort in cycle 6 of a frame -> cycle 7 has tx_out=0, tx_active=0 and in_ready=1; no frame_done occurs.
REQ-041 rst_n low in cycle 8 -> tx_out=0 asynchronously; after release, in_ready=1 and a new 8'h3C frame is correct.
REQ-042 Loopback into the 1001 sequence detector with payload 8'h00 -> detector fires exactly once per frame, aligned to the 4th sync bit.
